// File: rtl/gate_tt_checker.sv
// rtl/gate_tt_checker.sv - clocked truth-table sequencer/checker for two-input logic gates
//
// Drives every {a,b} combination into a gate under test, holds each one for
// SETTLE_CYCLES cycles, samples y for one cycle and compares it with the
// expected value for the latched gate_sel. Repeats the table LOOPS times.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   start            run request, accepted in IDLE only
//   abort            synchronous cancel of a run in progress
//   gate_sel         0=AND 1=OR 2=NAND 3=NOR 4=XOR 5=XNOR 6=NOT(a) 7=reserved
//   y                output of the gate under test
//   a, b             stimulus to the gate under test
//   busy             run in progress
//   done             one-cycle completion pulse
//   pass             last run had zero mismatches
//   err_cnt          saturating mismatch count of the last run
//   fail_vec         bit i set = combination {a,b}=i mismatched in any loop

module gate_tt_checker #(
    parameter int SETTLE_CYCLES = 2,
    parameter int LOOPS         = 1,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [2:0]       gate_sel,
    input  logic             y,
    output logic             a,
    output logic             b,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt,
    output logic [3:0]       fail_vec
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int LW = (LOOPS > 1) ? $clog2(LOOPS) : 1;

    localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [LW-1:0]    LOOP_LAST   = LW'(LOOPS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    // Reserved selector reports all four combinations as failed; clamp the
    // count in case the counter is too narrow to hold 4.
    localparam logic [CNT_W-1:0] RSV_ERRS    =
        (CNT_W >= 3) ? CNT_W'(4) : CNT_MAX;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    state_t          state;
    logic [2:0]      sel_q;
    logic [1:0]      idx;
    logic [LW-1:0]   loop_q;
    logic [SW-1:0]   settle_q;

    logic            exp_y;
    logic            mismatch;
    logic [CNT_W-1:0] err_next;
    logic [3:0]       fail_next;

    // Expected gate output for the currently driven a/b.
    always_comb begin
        exp_y = 1'b0;
        case (sel_q)
            3'd0:    exp_y = a & b;
            3'd1:    exp_y = a | b;
            3'd2:    exp_y = ~(a & b);
            3'd3:    exp_y = ~(a | b);
            3'd4:    exp_y = a ^ b;
            3'd5:    exp_y = ~(a ^ b);
            3'd6:    exp_y = ~a;
            default: exp_y = 1'b0;
        endcase
    end

    assign mismatch = (y != exp_y);

    always_comb begin
        err_next  = err_cnt;
        fail_next = fail_vec;
        if (mismatch) begin
            if (err_cnt != CNT_MAX) begin
                err_next = err_cnt + 1'b1;
            end
            fail_next[idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sel_q    <= 3'd0;
            idx      <= 2'd0;
            loop_q   <= '0;
            settle_q <= '0;
            a        <= 1'b0;
            b        <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            err_cnt  <= '0;
            fail_vec <= 4'b0000;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start && !abort) begin
                        sel_q    <= gate_sel;
                        pass     <= 1'b0;
                        idx      <= 2'd0;
                        loop_q   <= '0;
                        settle_q <= '0;
                        a        <= 1'b0;
                        b        <= 1'b0;
                        if (gate_sel == 3'd7) begin
                            // Reserved selector: nothing to drive, report at once.
                            err_cnt  <= RSV_ERRS;
                            fail_vec <= 4'b1111;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            state    <= DONE;
                        end else begin
                            err_cnt  <= '0;
                            fail_vec <= 4'b0000;
                            busy     <= 1'b1;
                            state    <= SETTLE;
                        end
                    end
                end

                SETTLE: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        a     <= 1'b0;
                        b     <= 1'b0;
                        pass  <= 1'b0;
                    end else if (settle_q == SETTLE_LAST) begin
                        state <= SAMPLE;
                    end else begin
                        settle_q <= settle_q + 1'b1;
                    end
                end

                SAMPLE: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        a     <= 1'b0;
                        b     <= 1'b0;
                        pass  <= 1'b0;
                    end else begin
                        err_cnt  <= err_next;
                        fail_vec <= fail_next;
                        settle_q <= '0;
                        if (idx != 2'd3) begin
                            idx   <= idx + 2'd1;
                            a     <= (idx + 2'd1) >> 1;
                            b     <= ~idx[0];
                            state <= SETTLE;
                        end else if (loop_q != LOOP_LAST) begin
                            loop_q <= loop_q + 1'b1;
                            idx    <= 2'd0;
                            a      <= 1'b0;
                            b      <= 1'b0;
                            state  <= SETTLE;
                        end else begin
                            // pass uses the count including this final compare.
                            a     <= 1'b0;
                            b     <= 1'b0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_next == '0);
                            state <= DONE;
                        end
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_tt_checker.sv
// tb/tb_gate_tt_checker.sv - scoreboard bench for gate_tt_checker

module tb_gate_tt_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       abort = 1'b0;
    logic [2:0] gate_sel = 3'd0;
    logic [1:0] start_s = 2'b00;
    logic [1:0] y_s, a_s, b_s, busy_s, done_s, pass_s;
    logic [7:0] err_s [2];
    logic [3:0] fv_s [2];

    // bench-side gate model: selector used by the fake gate, and fault mode per instance
    logic [2:0] run_sel = 3'd0;
    int         flt [2] = '{0, 0};

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic       pass;
        logic [7:0] err;
        logic [3:0] fv;
    } result_t;

    result_t sb [$];

    always #5 clk = ~clk;

    gate_tt_checker #(.SETTLE_CYCLES(2), .LOOPS(1), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start_s[0]), .abort(abort),
        .gate_sel(gate_sel), .y(y_s[0]), .a(a_s[0]), .b(b_s[0]),
        .busy(busy_s[0]), .done(done_s[0]), .pass(pass_s[0]),
        .err_cnt(err_s[0]), .fail_vec(fv_s[0])
    );

    gate_tt_checker #(.SETTLE_CYCLES(2), .LOOPS(3), .CNT_W(8)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start_s[1]), .abort(abort),
        .gate_sel(gate_sel), .y(y_s[1]), .a(a_s[1]), .b(b_s[1]),
        .busy(busy_s[1]), .done(done_s[1]), .pass(pass_s[1]),
        .err_cnt(err_s[1]), .fail_vec(fv_s[1])
    );

    function automatic logic ideal(input logic [2:0] sel, input logic ai, input logic bi);
        case (sel)
            3'd0: return ai & bi;
            3'd1: return ai | bi;
            3'd2: return !(ai & bi);
            3'd3: return !(ai | bi);
            3'd4: return ai ^ bi;
            3'd5: return !(ai ^ bi);
            3'd6: return !ai;
            default: return 1'b0;
        endcase
    endfunction

    // fault 0 = correct gate, 1 = stuck at 0, 2 = stuck at 1, 3 = wrong output at {a,b}=01
    function automatic logic faulty(input logic [2:0] sel, input int f, input logic ai, input logic bi);
        case (f)
            1: return 1'b0;
            2: return 1'b1;
            3: return ideal(sel, ai, bi) ^ (!ai && bi);
            default: return ideal(sel, ai, bi);
        endcase
    endfunction

    assign y_s[0] = faulty(run_sel, flt[0], a_s[0], b_s[0]);
    assign y_s[1] = faulty(run_sel, flt[1], a_s[1], b_s[1]);

    function automatic result_t model(input logic [2:0] sel, input int f, input int loops);
        result_t r;
        r.err = 8'd0;
        r.fv  = 4'b0000;
        if (sel == 3'd7) begin
            r.pass = 1'b0;
            r.err  = 8'd4;
            r.fv   = 4'b1111;
            return r;
        end
        for (int l = 0; l < loops; l++) begin
            for (int i = 0; i < 4; i++) begin
                logic ai, bi;
                ai = (i >= 2);
                bi = (i % 2 == 1);
                if (faulty(sel, f, ai, bi) != ideal(sel, ai, bi)) begin
                    r.err = r.err + 8'd1;
                    r.fv[i] = 1'b1;
                end
            end
        end
        r.pass = (r.err == 8'd0);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete run on instance inst; exp_edge = edge (after the start edge)
    // at which done goes high. repulse re-asserts start and changes gate_sel mid-run.
    task automatic run(input int inst, input logic [2:0] sel, input int f,
                       input int loops, input int exp_edge, input bit repulse);
        int n;
        result_t e;
        sb.push_back(model(sel, f, loops));
        run_sel = sel;
        flt[inst] = f;
        gate_sel = sel;
        start_s[inst] = 1'b1;
        step();
        start_s[inst] = 1'b0;
        n = 0;
        while (!done_s[inst] && n < 200) begin
            if (n == 1) chk("busy_in_run", busy_s[inst], 1);
            if (inst == 0 && n % 3 == 1 && n < 12)
                chk("ab_step", {a_s[inst], b_s[inst]}, n / 3);
            if (repulse && n == 5) begin
                start_s[inst] = 1'b1;
                gate_sel = 3'd7;
            end
            if (n == 6) start_s[inst] = 1'b0;
            step();
            n++;
        end
        gate_sel = sel;
        chk("done_seen", done_s[inst], 1);
        chk("done_edge", n, exp_edge);
        chk("busy_at_done", busy_s[inst], 0);
        chk("ab_at_done", {a_s[inst], b_s[inst]}, 0);
        if (sb.size() == 0) begin
            chk("sb_nonempty", 0, 1);
        end else begin
            e = sb.pop_front();
            chk("pass", pass_s[inst], e.pass);
            chk("err_cnt", err_s[inst], e.err);
            chk("fail_vec", fv_s[inst], e.fv);
        end
        step();
        chk("done_one_cycle", done_s[inst], 0);
        chk("result_hold", {pass_s[inst], err_s[inst], fv_s[inst]}, {e.pass, e.err, e.fv});
    endtask

    initial begin
        int dcount;

        // reset state
        repeat (3) step();
        chk("rst_ab", {a_s[0], b_s[0]}, 0);
        chk("rst_busy_done", {busy_s[0], done_s[0]}, 0);
        chk("rst_pass", pass_s[0], 0);
        chk("rst_err", err_s[0], 0);
        chk("rst_fv", fv_s[0], 0);
        rst_n = 1'b1;
        step();

        // correct AND, single loop
        run(0, 3'd0, 0, 1, 12, 1'b0);
        // XNOR stuck at 0, with ignored mid-run start and gate_sel change
        run(0, 3'd5, 1, 1, 12, 1'b1);
        // AND stuck at 1, three loops
        run(1, 3'd0, 2, 3, 36, 1'b0);
        // reserved selector
        run(0, 3'd7, 0, 1, 0, 1'b0);
        // NOT with b ignored
        run(0, 3'd6, 0, 1, 12, 1'b0);
        // NAND with a single wrong combination
        run(0, 3'd2, 3, 1, 12, 1'b0);

        // abort in SETTLE of idx 2 after a mismatch at idx 1
        run_sel = 3'd0;
        flt[0] = 3;
        gate_sel = 3'd0;
        start_s[0] = 1'b1;
        step();
        start_s[0] = 1'b0;
        dcount = 0;
        repeat (6) begin
            step();
            dcount += done_s[0];
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_busy", busy_s[0], 0);
        chk("abort_ab", {a_s[0], b_s[0]}, 0);
        chk("abort_pass", pass_s[0], 0);
        chk("abort_err", err_s[0], 1);
        chk("abort_fv", fv_s[0], 4'b0010);
        repeat (5) begin
            step();
            dcount += done_s[0];
        end
        chk("abort_no_done", dcount, 0);
        run(0, 3'd0, 0, 1, 12, 1'b0);

        // abort together with start in IDLE
        abort = 1'b1;
        start_s[0] = 1'b1;
        step();
        abort = 1'b0;
        start_s[0] = 1'b0;
        step();
        chk("abort_start_idle", {busy_s[0], done_s[0]}, 0);

        // re-pulsed start while busy, then reset in SAMPLE
        flt[0] = 0;
        start_s[0] = 1'b1;
        step();
        start_s[0] = 1'b0;
        step();
        start_s[0] = 1'b1;
        step();
        start_s[0] = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outputs",
            {a_s[0], b_s[0], busy_s[0], done_s[0], pass_s[0], err_s[0], fv_s[0]}, 0);
        dcount = 0;
        repeat (2) begin
            step();
            dcount += done_s[0];
        end
        rst_n = 1'b1;
        repeat (3) begin
            step();
            dcount += done_s[0];
        end
        chk("rst_no_done", dcount, 0);
        chk("rst_stays_idle", busy_s[0], 0);
        chk("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
